univ_shift_reg: RTL and testbench

Parametrised multi-mode register: the next generation of the single-bit D flip-flop. Holds a WIDTH-bit word and executes one command per START: hold, parallel load, clear, or a multi-step shift or rotate of AMT positions, one position per clock. It reports progress through BUSY and DONE. It is the storage and shift element for the sequential datapath exercises (serialisers, multipliers, LFSR front-ends).

---
 rtl/univ_shift_reg_if.sv | 26 ++
 rtl/univ_shift_reg.sv | 163 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// Command/status bundle for the universal shift register.
// master drives commands and serial data in; slave returns the word and status.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             START;
    logic [2:0]       MODE;
    logic [AMT_W-1:0] AMT;
    logic [WIDTH-1:0] D;
    logic             SIN;
    logic [WIDTH-1:0] Q;
    logic             SOUT;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, MODE, AMT, D, SIN,
        input  Q, SOUT, BUSY, DONE
    );

    modport slave (
        input  START, MODE, AMT, D, SIN,
        output Q, SOUT, BUSY, DONE
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / load / clear in one cycle, shifts and
// rotates of AMT single-bit steps, one step per clock, with BUSY/DONE status.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for START; single-cycle commands and step 1 happen here
//  SHIFT | multi-step command running, cnt = steps still to perform
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    univ_shift_reg_if.slave   bus
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [AMT_W-1:0] AMT_ZERO = '0;
    localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic             sout, sout_nxt;
    logic             done, done_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       mode_r, mode_nxt;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;

    // While a command runs, the captured mode drives the step; MODE on the
    // bus only matters at the accepting edge.
    assign step_mode = (state == SHIFT) ? mode_r : bus.MODE;

    // One single-bit step of the selected shift or rotate.
    always_comb begin
        step_q    = q;
        step_sout = sout;
        case (step_mode)
            MODE_SHL: begin
                step_q    = {q[WIDTH-2:0], bus.SIN};
                step_sout = q[WIDTH-1];
            end
            MODE_SHR: begin
                step_q    = {bus.SIN, q[WIDTH-1:1]};
                step_sout = q[0];
            end
            MODE_ROL: begin
                step_q    = {q[WIDTH-2:0], q[WIDTH-1]};
                step_sout = q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q    = {q[0], q[WIDTH-1:1]};
                step_sout = q[0];
            end
            MODE_ASR: begin
                step_q    = {q[WIDTH-1], q[WIDTH-1:1]};
                step_sout = q[0];
            end
            default: begin
                step_q    = q;
                step_sout = sout;
            end
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        sout_nxt  = sout;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt;
        mode_nxt  = mode_r;

        case (state)
            IDLE: begin
                if (bus.START) begin
                    mode_nxt = bus.MODE;
                    case (bus.MODE)
                        MODE_HOLD: begin
                            done_nxt = 1'b1;
                        end
                        MODE_LOAD: begin
                            q_nxt    = bus.D;
                            done_nxt = 1'b1;
                        end
                        MODE_CLEAR: begin
                            q_nxt    = '0;
                            done_nxt = 1'b1;
                        end
                        default: begin
                            if (bus.AMT == AMT_ZERO) begin
                                done_nxt = 1'b1;
                            end else begin
                                // The accepting edge already performs step 1.
                                q_nxt    = step_q;
                                sout_nxt = step_sout;
                                cnt_nxt  = bus.AMT - AMT_ONE;
                                if (bus.AMT == AMT_ONE) begin
                                    done_nxt = 1'b1;
                                end else begin
                                    state_nxt = SHIFT;
                                end
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                q_nxt    = step_q;
                sout_nxt = step_sout;
                cnt_nxt  = cnt - AMT_ONE;
                if (cnt == AMT_ONE) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            q      <= '0;
            sout   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mode_r <= MODE_HOLD;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            sout   <= sout_nxt;
            done   <= done_nxt;
            cnt    <= cnt_nxt;
            mode_r <= mode_nxt;
        end
    end

    assign bus.Q    = q;
    assign bus.SOUT = sout;
    assign bus.BUSY = (state == SHIFT);
    assign bus.DONE = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int AW = 4;

    logic CLK;
    logic RESET;

    univ_shift_reg_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // reference model state
    logic [W-1:0] m_q    = '0;
    logic         m_sout = 1'b0;
    logic         m_done = 1'b0;
    int           m_rem  = 0;
    logic [2:0]   m_mode = 3'd0;

    // One step as plain arithmetic on the word value: returns {sout, q}.
    function automatic logic [W:0] mstep(input logic [2:0] mode, input logic [W-1:0] qv, input logic sin);
        longint v, full, half, msb, lsb, nq, so;
        v    = longint'(qv);
        full = longint'(1) << W;
        half = longint'(1) << (W - 1);
        msb  = v / half;
        lsb  = v % 2;
        nq   = v;
        so   = 0;
        case (mode)
            3'd2: begin nq = (v * 2 + longint'(sin)) % full; so = msb; end
            3'd3: begin nq = v / 2 + longint'(sin) * half;   so = lsb; end
            3'd4: begin nq = (v * 2 + msb) % full;           so = msb; end
            3'd5: begin nq = v / 2 + lsb * half;             so = lsb; end
            default: begin nq = v / 2 + msb * half;          so = lsb; end
        endcase
        return {so[0], nq[W-1:0]};
    endfunction

    always @(posedge CLK) begin
        if (!RESET) begin
            m_q = '0; m_sout = 1'b0; m_rem = 0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            {m_sout, m_q} = mstep(m_mode, m_q, bus.SIN);
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
        end else begin
            m_done = 1'b0;
            if (bus.START) begin
                m_mode = bus.MODE;
                m_done = 1'b1;
                case (bus.MODE)
                    3'd0: ;
                    3'd1: m_q = bus.D;
                    3'd7: m_q = '0;
                    default: begin
                        if (bus.AMT != 0) begin
                            {m_sout, m_q} = mstep(bus.MODE, m_q, bus.SIN);
                            m_rem  = int'(bus.AMT) - 1;
                            m_done = (m_rem == 0);
                        end
                    end
                endcase
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            n_tests++;
            if (bus.Q !== m_q) begin
                n_fail++;
                $display("FAIL q @%0t: got %02h expected %02h", $time, bus.Q, m_q);
            end
            n_tests++;
            if (bus.SOUT !== m_sout) begin
                n_fail++;
                $display("FAIL sout @%0t: got %0b expected %0b", $time, bus.SOUT, m_sout);
            end
            n_tests++;
            if (bus.BUSY !== (m_rem > 0)) begin
                n_fail++;
                $display("FAIL busy @%0t: got %0b expected %0b", $time, bus.BUSY, (m_rem > 0));
            end
            n_tests++;
            if (bus.DONE !== m_done) begin
                n_fail++;
                $display("FAIL done @%0t: got %0b expected %0b", $time, bus.DONE, m_done);
            end
            n_tests++;
            if (bus.BUSY === 1'b1 && bus.DONE === 1'b1) begin
                n_fail++;
                $display("FAIL busy_and_done @%0t: got both 1 expected not both", $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a command for one edge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] mode, input logic [AW-1:0] amt,
                         input logic [W-1:0] d, input logic sin);
        bus.START = 1'b1; bus.MODE = mode; bus.AMT = amt; bus.D = d; bus.SIN = sin;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    // Wait until DONE is seen, counting cycles with BUSY high.
    task automatic wait_done(input string name, input int maxc, output int busy_cnt);
        int i;
        busy_cnt = 0;
        for (i = 0; i < maxc; i++) begin
            if (bus.DONE === 1'b1) break;
            if (bus.BUSY === 1'b1) busy_cnt++;
            @(negedge CLK);
        end
        if (i == maxc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got no DONE expected DONE within %0d cycles", name, maxc);
        end
    endtask

    initial begin
        int bc;
        RESET = 1'b0;
        bus.START = 1'b0; bus.MODE = 3'd0; bus.AMT = '0; bus.D = '0; bus.SIN = 1'b0;
        @(negedge CLK); @(negedge CLK);
        chk("reset_q", 32'(bus.Q), 32'h00);
        chk("reset_busy_done", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
        chk("reset_sout", 32'(bus.SOUT), 32'd0);
        chk_en = 1'b1;
        RESET = 1'b1;
        @(negedge CLK);

        // load and hold
        issue(3'b001, 4'd0, 8'hA5, 1'b0);
        chk("load_q", 32'(bus.Q), 32'hA5);
        chk("load_done", {30'd0, bus.BUSY, bus.DONE}, 32'd1);
        issue(3'b000, 4'd0, 8'h00, 1'b0);
        chk("hold_q", 32'(bus.Q), 32'hA5);
        chk("hold_done", 32'(bus.DONE), 32'd1);
        @(negedge CLK);
        chk("hold_done_drop", 32'(bus.DONE), 32'd0);

        // SHL 3 with SIN=1 from 0xA5
        issue(3'b010, 4'd3, 8'h00, 1'b1);
        chk("shl_step1", {23'd0, bus.BUSY, bus.Q}, {23'd0, 1'b1, 8'h4B});
        @(negedge CLK);
        chk("shl_step2", {23'd0, bus.BUSY, bus.Q}, {23'd0, 1'b1, 8'h97});
        @(negedge CLK);
        chk("shl_final", {22'd0, bus.BUSY, bus.DONE, bus.Q}, {22'd0, 2'b01, 8'h2F});
        chk("shl_sout", 32'(bus.SOUT), 32'd1);
        @(negedge CLK);

        // ASR 2 from 0x84, then ROR 9 from 0x81
        issue(3'b001, 4'd0, 8'h84, 1'b0);
        issue(3'b110, 4'd2, 8'h00, 1'b0);
        wait_done("asr", 5, bc);
        chk("asr_q", 32'(bus.Q), 32'hE1);
        chk("asr_sout", 32'(bus.SOUT), 32'd0);
        issue(3'b001, 4'd0, 8'h81, 1'b0);
        issue(3'b101, 4'd9, 8'h00, 1'b0);
        wait_done("ror", 12, bc);
        chk("ror9_q", 32'(bus.Q), 32'hC0);
        chk("ror9_sout", 32'(bus.SOUT), 32'd1);
        chk("ror9_busy_cycles", 32'(bc), 32'd8);

        // SHR 12 with SIN=0 from 0x5A
        issue(3'b001, 4'd0, 8'h5A, 1'b0);
        issue(3'b011, 4'd12, 8'h00, 1'b0);
        wait_done("shr12", 16, bc);
        chk("shr12_q", 32'(bus.Q), 32'h00);
        chk("shr12_busy_cycles", 32'(bc), 32'd11);

        // START while busy is ignored
        issue(3'b001, 4'd0, 8'h0F, 1'b0);
        issue(3'b010, 4'd4, 8'h00, 1'b0);
        bus.START = 1'b1; bus.MODE = 3'b001; bus.D = 8'h33; bus.AMT = 4'd1;
        @(negedge CLK);
        bus.MODE = 3'b111;
        @(negedge CLK);
        bus.START = 1'b0;
        wait_done("busy_ignore", 6, bc);
        chk("busy_ignore_q", 32'(bus.Q), 32'hF0);

        // SHL AMT=0, then back-to-back command in the DONE cycle
        @(negedge CLK);
        issue(3'b010, 4'd0, 8'h00, 1'b1);
        chk("amt0_q", 32'(bus.Q), 32'hF0);
        chk("amt0_done", {30'd0, bus.BUSY, bus.DONE}, 32'd1);
        issue(3'b001, 4'd0, 8'h3C, 1'b0);
        chk("b2b_q", 32'(bus.Q), 32'h3C);
        chk("b2b_done", 32'(bus.DONE), 32'd1);

        // reset in the middle of a command, START held during reset
        issue(3'b001, 4'd0, 8'hFF, 1'b0);
        issue(3'b010, 4'd5, 8'h00, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        bus.START = 1'b1; bus.MODE = 3'b001; bus.D = 8'hAA;
        @(negedge CLK);
        chk("rst_mid_q", 32'(bus.Q), 32'h00);
        chk("rst_mid_flags", {29'd0, bus.BUSY, bus.DONE, bus.SOUT}, 32'd0);
        @(negedge CLK);
        chk("rst_start_q", 32'(bus.Q), 32'h00);
        chk("rst_start_flags", {29'd0, bus.BUSY, bus.DONE, bus.SOUT}, 32'd0);
        RESET = 1'b1;
        bus.START = 1'b0;
        @(negedge CLK);

        // randomized traffic, model checks every cycle
        for (int i = 0; i < 4000; i++) begin
            RESET     = ($urandom_range(0, 99) != 0);
            bus.START = ($urandom_range(0, 2) != 0);
            bus.MODE  = 3'($urandom_range(0, 7));
            bus.AMT   = AW'($urandom_range(0, 15));
            bus.D     = W'($urandom);
            bus.SIN   = 1'($urandom);
            @(negedge CLK);
        end

        RESET = 1'b1;
        bus.START = 1'b0;
        @(negedge CLK);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
